// File: rtl/param_cache_mem.sv
// Direct-mapped write-back/write-allocate cache with embedded backing memory; optional CACHE_STATS_EN adds hit/miss/writeback counters.
// Latency: hit 1 cycle, clean miss 1+MEM_LAT, dirty miss 1+2*MEM_LAT (accept to rsp_valid).
// Backpressure: req_ready only in IDLE, requests offered while busy are ignored; response has no backpressure.
module param_cache_mem #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 5,
   parameter int NUM_LINES = 4,
   parameter int MEM_LAT   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_hit
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt,
   output logic [15:0]       wb_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam int MEM_D = 1 << ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_RESP} state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_hit;
   logic                r_vld [NUM_LINES];
   logic                r_dty [NUM_LINES];
   logic [ADDR_W-1:0]   r_tag [NUM_LINES];
   logic [DATA_W-1:0]   r_dat [NUM_LINES];
   logic [DATA_W-1:0]   r_mem [MEM_D];

   logic                w_accept;
   logic [IDX_W-1:0]    w_req_idx;
   logic [IDX_W-1:0]    w_cur_idx;
   logic                w_hit;
   logic                w_victim_dirty;
   logic                w_last;
   logic [DATA_W-1:0]   w_fill_dat;

   assign w_accept       = req_valid && (r_state == S_IDLE);
   assign w_req_idx      = req_addr[ADDR_W-1 -: IDX_W];
   assign w_cur_idx      = r_addr[ADDR_W-1 -: IDX_W];
   assign w_hit          = r_vld[w_req_idx] && (r_tag[w_req_idx] == req_addr);
   assign w_victim_dirty = r_vld[w_req_idx] && r_dty[w_req_idx];
   assign w_last         = (r_cnt == CNT_W'(MEM_LAT - 1));
   assign w_fill_dat     = r_wr ? r_wdata : r_mem[r_addr];

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_hit   = r_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) begin
            if (w_hit)               w_next = S_RESP;
            else if (w_victim_dirty) w_next = S_WB;
            else                     w_next = S_FILL;
         end
         S_WB:    if (w_last) w_next = S_FILL;
         S_FILL:  if (w_last) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_hit   <= 1'b0;
         for (int i = 0; i < NUM_LINES; i++) begin
            r_vld[i] <= 1'b0;
            r_dty[i] <= 1'b0;
            r_tag[i] <= '0;
            r_dat[i] <= '0;
         end
         for (int j = 0; j < MEM_D; j++) r_mem[j] <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_wr    <= req_wr;
               r_addr  <= req_addr;
               r_wdata <= req_wdata;
               r_cnt   <= '0;
               r_hit   <= w_hit;
               if (w_hit) begin
                  if (req_wr) begin
                     r_dat[w_req_idx] <= req_wdata;
                     r_dty[w_req_idx] <= 1'b1;
                     r_rdata          <= req_wdata;
                  end else begin
                     r_rdata <= r_dat[w_req_idx];
                  end
               end
            end
            S_WB: begin
               if (w_last) begin
                  r_mem[r_tag[w_cur_idx]] <= r_dat[w_cur_idx];
                  r_cnt                   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_FILL: begin
               // Write miss allocates and merges the new word in the same step.
               if (w_last) begin
                  r_vld[w_cur_idx] <= 1'b1;
                  r_tag[w_cur_idx] <= r_addr;
                  r_dty[w_cur_idx] <= r_wr;
                  r_dat[w_cur_idx] <= w_fill_dat;
                  r_rdata          <= w_fill_dat;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] r_hit_cnt;
   logic [15:0] r_miss_cnt;
   logic [15:0] r_wb_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_wb_cnt   <= '0;
      end else begin
         if (r_state == S_RESP) begin
            if (r_hit && r_hit_cnt != 16'hFFFF)   r_hit_cnt  <= r_hit_cnt + 16'd1;
            if (!r_hit && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
         end
         if (r_state == S_WB && w_last && r_wb_cnt != 16'hFFFF) r_wb_cnt <= r_wb_cnt + 16'd1;
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
   assign wb_cnt   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_param_cache_mem.sv
// Scoreboarded random bench for param_cache_mem against a flat-memory reference model.
module tb_param_cache_mem;
   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int NL    = 4;
   localparam int ML    = 2;
   localparam int IDX_W = $clog2(NL);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_wr = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_hit;
`ifdef CACHE_STATS_EN
   logic [15:0]   hit_cnt, miss_cnt, wb_cnt;
`endif

   param_cache_mem #(.DATA_W(DW), .ADDR_W(AW), .NUM_LINES(NL), .MEM_LAT(ML)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit)
`ifdef CACHE_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          hit;
      int            acc;
      int            lat;
   } exp_t;
   exp_t q[$];

   // Reference: the program-visible memory image plus which address each line holds.
   logic [DW-1:0] g_mem [1<<AW];
   bit            m_v [NL];
   bit            m_d [NL];
   logic [AW-1:0] m_t [NL];
   int            m_hits, m_miss, m_wb;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < (1<<AW); i++) g_mem[i] = '0;
      for (int i = 0; i < NL; i++) begin
         m_v[i] = 0; m_d[i] = 0; m_t[i] = '0;
      end
      m_hits = 0; m_miss = 0; m_wb = 0;
      q.delete();
   endtask

   task automatic model_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      int idx;
      idx = int'(a) / ((1<<AW) / NL);
      e.hit = m_v[idx] && (m_t[idx] == a);
      if (e.hit) begin
         e.lat = 1; m_hits++;
      end else begin
         m_miss++;
         if (m_v[idx] && m_d[idx]) begin
            e.lat = 1 + 2*ML; m_wb++;
         end else begin
            e.lat = 1 + ML;
         end
      end
      if (wr) g_mem[a] = d;
      e.rdata = g_mem[a];
      m_d[idx] = e.hit ? (m_d[idx] | wr) : wr;
      m_v[idx] = 1;
      m_t[idx] = a;
      e.acc = cyc + 1;
      q.push_back(e);
   endtask

   // Drives at a negedge and holds until req_ready; returns at the negedge after the accepting edge.
   task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit push);
      int waitn = 0;
      @(negedge clk);
      req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d;
      while (!req_ready && waitn < 100) begin
         @(negedge clk);
         waitn++;
      end
      if (!req_ready) begin
         chk("ready_timeout", 0, 1);
         req_valid = 0;
         return;
      end
      if (push) model_req(wr, a, d);
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
   endtask

   task automatic reset_pulse();
      rst_n = 0;
      req_valid = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_hit", rsp_hit, 0);
   endtask

   logic [DW-1:0] last_rd = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         last_rd = '0;
      end else if (rsp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
         end else begin
            e = q.pop_front();
            chk("rdata", rsp_rdata, e.rdata);
            chk("hit", rsp_hit, e.hit);
            chk("latency", cyc - e.acc + 1, e.lat);
         end
         last_rd = rsp_rdata;
      end else begin
         chk("rdata_hold", rsp_rdata, last_rd);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      @(negedge clk);
      reset_pulse();

      send(0, 5'd5, 8'h00, 1);
      send(1, 5'd9, 8'h3C, 1);
      send(0, 5'd9, 8'h00, 1);
      send(1, 5'd16, 8'hA5, 1);
      send(0, 5'd20, 8'h00, 1);
      send(0, 5'd16, 8'h00, 1);
      send(1, 5'd3, 8'h11, 1);
      send(1, 5'd3, 8'h22, 1);
      send(0, 5'd3, 8'h00, 1);
      drain();

      // Abort a read miss mid-FILL: no response may appear.
      send(0, 5'd30, 8'h00, 0);
      chk("abort_busy", req_ready, 0);
      reset_pulse();

      send(1, 5'd16, 8'hA5, 1);
      send(0, 5'd20, 8'h00, 1);
      send(0, 5'd16, 8'h00, 1);
      drain();
      @(negedge clk);
`ifdef CACHE_STATS_EN
      chk("sc3_hit_cnt", hit_cnt, 0);
      chk("sc3_miss_cnt", miss_cnt, 3);
      chk("sc3_wb_cnt", wb_cnt, 1);
`endif
      send(0, 5'd30, 8'h00, 1);
      drain();

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         send(1'($urandom_range(0, 1)), AW'($urandom_range(0, (1<<AW)-1)), DW'($urandom), 1);
      end
      drain();
      @(negedge clk);
`ifdef CACHE_STATS_EN
      chk("hit_cnt", hit_cnt, m_hits);
      chk("miss_cnt", miss_cnt, m_miss);
      chk("wb_cnt", wb_cnt, m_wb);
`endif
      chk("queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
